// File: rtl/axi_read_tracker.sv
// Read-path engine: holds up to MAX_OUT outstanding INCR read bursts, issues
// one beat address per cycle to memory and returns lane-shifted R beats.
module axi_read_tracker #(
  parameter int ID_W       = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int MEM_ADDR_W = 8,
  parameter int MEM_BYTES  = 256,
  parameter int MAX_OUT    = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [ID_W-1:0]       ARID,
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_W-1:0]       RID,
  output logic [DATA_W-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [MEM_ADDR_W-1:0] raddr,
  output logic [ID_W-1:0]       rtid,
  output logic                  rstrobe,
  input  logic                  rfull,
  input  logic                  rvalid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [ID_W-1:0]       tid_out,
  input  logic                  rerr,
  output logic                  ren,
  output logic                  stray
);
  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int SW     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int EW     = ADDR_W + 17;

  logic                  r_vld  [MAX_OUT];
  logic [ID_W-1:0]       r_id   [MAX_OUT];
  logic [MEM_ADDR_W-1:0] r_base [MAX_OUT];
  logic [7:0]            r_len  [MAX_OUT];
  logic [2:0]            r_size [MAX_OUT];
  logic [8:0]            r_icnt [MAX_OUT];
  logic [8:0]            r_rcnt [MAX_OUT];
  logic                  r_err  [MAX_OUT];
  logic [SW-1:0]         r_rr_ptr;
  logic [SW-1:0]         r_rslot;

  logic          w_free_found, w_id_hit, w_match_found, w_inj_found, w_iss_found;
  logic [SW-1:0] w_free_idx, w_match_idx, w_inj_idx, w_iss_idx;
  logic          w_ar_hs, w_ar_err, w_mem_acc, w_mem_load, w_inj, w_r_free;
  logic [EW-1:0] w_end;

  function automatic logic [MEM_ADDR_W-1:0] f_beat_addr(input logic [MEM_ADDR_W-1:0] base,
                                                        input logic [2:0] size,
                                                        input logic [8:0] n);
    logic [MEM_ADDR_W-1:0] aligned;
    aligned = base & ({MEM_ADDR_W{1'b1}} << size);
    return (n == 9'd0) ? base : aligned + (MEM_ADDR_W'(n) << size);
  endfunction

  function automatic logic [DATA_W-1:0] f_lane_data(input logic [DATA_W-1:0] data,
                                                    input logic [2:0] size,
                                                    input logic [MEM_ADDR_W-1:0] addr);
    logic [DATA_W-1:0]     mask;
    logic [MEM_ADDR_W-1:0] lane;
    for (int b = 0; b < NB; b++) begin
      mask[b*8 +: 8] = (b < (32'sd1 <<< size)) ? 8'hFF : 8'h00;
    end
    lane = addr & MEM_ADDR_W'(NB - 1);
    return (data & mask) << {lane, 3'b000};
  endfunction

  // Slot lookups: lowest free slot, ARID/tid_out hits, lowest pending err slot.
  always_comb begin
    w_free_found  = 1'b0;
    w_free_idx    = '0;
    w_id_hit      = 1'b0;
    w_match_found = 1'b0;
    w_match_idx   = '0;
    w_inj_found   = 1'b0;
    w_inj_idx     = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      w_free_found  = w_free_found | ~r_vld[i];
      w_free_idx    = r_vld[i] ? w_free_idx : SW'(i);
      w_id_hit      = w_id_hit | (r_vld[i] & (r_id[i] == ARID));
      w_match_found = w_match_found | (r_vld[i] & (r_id[i] == tid_out));
      w_match_idx   = (r_vld[i] && r_id[i] == tid_out) ? SW'(i) : w_match_idx;
      w_inj_found   = w_inj_found | (r_vld[i] & r_err[i] & (r_rcnt[i] <= {1'b0, r_len[i]}));
      w_inj_idx     = (r_vld[i] && r_err[i] && r_rcnt[i] <= {1'b0, r_len[i]}) ? SW'(i) : w_inj_idx;
    end
  end

  // Round-robin issue pick, scanning from the slot after the last one served.
  always_comb begin
    int j;
    j           = 0;
    w_iss_found = 1'b0;
    w_iss_idx   = '0;
    for (int k = MAX_OUT - 1; k >= 0; k--) begin
      j = (int'(r_rr_ptr) + k) % MAX_OUT;
      w_iss_found = w_iss_found | (r_vld[j] & ~r_err[j] & (r_icnt[j] <= {1'b0, r_len[j]}));
      w_iss_idx   = (r_vld[j] && !r_err[j] && r_icnt[j] <= {1'b0, r_len[j]}) ? SW'(j) : w_iss_idx;
    end
  end

  assign w_end      = EW'(ARADDR) + (EW'({1'b0, ARLEN} + 9'd1) << ARSIZE);
  assign w_ar_err   = (ARBURST != 2'b01) || (ARSIZE > 3'(LANE_W)) || (w_end > EW'(MEM_BYTES));
  assign ARREADY    = n_rst & w_free_found & ~w_id_hit;
  assign w_ar_hs    = ARVALID & ARREADY;
  assign ren        = ~RVALID | RREADY;
  assign w_mem_acc  = rvalid & ren;
  assign w_mem_load = w_mem_acc & w_match_found;
  assign stray      = n_rst & w_mem_acc & ~w_match_found;
  assign w_inj      = ren & ~rvalid & w_inj_found;
  assign w_r_free   = RVALID & RREADY & RLAST;
  assign rstrobe    = w_iss_found & ~rfull;
  assign raddr      = rstrobe ? f_beat_addr(r_base[w_iss_idx], r_size[w_iss_idx], r_icnt[w_iss_idx]) : '0;
  assign rtid       = rstrobe ? r_id[w_iss_idx] : '0;

  // Slot table: fill on AR handshake, count issued/returned beats, free on RLAST handshake.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        r_vld[i]  <= 1'b0;
        r_id[i]   <= '0;
        r_base[i] <= '0;
        r_len[i]  <= 8'd0;
        r_size[i] <= 3'd0;
        r_icnt[i] <= 9'd0;
        r_rcnt[i] <= 9'd0;
        r_err[i]  <= 1'b0;
      end
      r_rr_ptr <= '0;
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (w_ar_hs && w_free_idx == SW'(i)) begin
          r_vld[i]  <= 1'b1;
          r_id[i]   <= ARID;
          r_base[i] <= ARADDR[MEM_ADDR_W-1:0];
          r_len[i]  <= ARLEN;
          r_size[i] <= ARSIZE;
          r_icnt[i] <= 9'd0;
          r_rcnt[i] <= 9'd0;
          r_err[i]  <= w_ar_err;
        end else begin
          if (rstrobe && w_iss_idx == SW'(i)) r_icnt[i] <= r_icnt[i] + 9'd1;
          if ((w_mem_load && w_match_idx == SW'(i)) || (w_inj && w_inj_idx == SW'(i)))
            r_rcnt[i] <= r_rcnt[i] + 9'd1;
          if (w_r_free && r_rslot == SW'(i)) r_vld[i] <= 1'b0;
        end
      end
      if (rstrobe) r_rr_ptr <= (w_iss_idx == SW'(MAX_OUT - 1)) ? '0 : w_iss_idx + SW'(1);
    end
  end

  // R output register: memory responses take priority over SLVERR injection.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      RVALID  <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= 2'b00;
      RLAST   <= 1'b0;
      r_rslot <= '0;
    end else if (w_mem_load) begin
      RVALID  <= 1'b1;
      RID     <= r_id[w_match_idx];
      RDATA   <= f_lane_data(rdata, r_size[w_match_idx],
                   f_beat_addr(r_base[w_match_idx], r_size[w_match_idx], r_rcnt[w_match_idx]));
      RRESP   <= rerr ? 2'b10 : 2'b00;
      RLAST   <= (r_rcnt[w_match_idx] == {1'b0, r_len[w_match_idx]});
      r_rslot <= w_match_idx;
    end else if (w_inj) begin
      RVALID  <= 1'b1;
      RID     <= r_id[w_inj_idx];
      RDATA   <= '0;
      RRESP   <= 2'b10;
      RLAST   <= (r_rcnt[w_inj_idx] == {1'b0, r_len[w_inj_idx]});
      r_rslot <= w_inj_idx;
    end else if (RREADY) begin
      RVALID  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_read_tracker.sv
// Directed bench for axi_read_tracker: hand-computed expectations checked with
// immediate assertions, stimulus as one linear sequence of steps.
module tb_axi_read_tracker;
  logic        clk;
  logic        n_rst;
  logic [1:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        ar_valid;
  logic        ar_ready;
  logic [1:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_valid;
  logic        r_ready;
  logic [7:0]  m_addr;
  logic [1:0]  m_tid;
  logic        m_strobe;
  logic        m_full;
  logic        m_valid;
  logic [63:0] m_data;
  logic [1:0]  m_tid_out;
  logic        m_err;
  logic        m_ren;
  logic        m_stray;

  int total = 0;
  int bad   = 0;

  logic [7:0]  iss_addr [12] = '{8'h10, 8'h40, 8'h80, 8'h00, 8'h18, 8'h48,
                                 8'h88, 8'h08, 8'h20, 8'h50, 8'h90, 8'h58};
  logic [1:0]  iss_tid  [12] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                                 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
  logic [1:0]  rsp_tid  [12] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2,
                                 2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0};
  logic        rsp_last [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  axi_read_tracker dut (
    .clk(clk), .n_rst(n_rst),
    .ARID(ar_id), .ARADDR(ar_addr), .ARLEN(ar_len), .ARSIZE(ar_size),
    .ARBURST(ar_burst), .ARVALID(ar_valid), .ARREADY(ar_ready),
    .RID(r_id), .RDATA(r_data), .RRESP(r_resp), .RLAST(r_last),
    .RVALID(r_valid), .RREADY(r_ready),
    .raddr(m_addr), .rtid(m_tid), .rstrobe(m_strobe), .rfull(m_full),
    .rvalid(m_valid), .rdata(m_data), .tid_out(m_tid_out), .rerr(m_err),
    .ren(m_ren), .stray(m_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ar(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    ar_valid = 1'b1;
    #1;
    chk("arready_accept", ar_ready, 1);
    tick();
    ar_valid = 1'b0;
  endtask

  task automatic iss(input logic [7:0] a, input logic [1:0] t);
    #1;
    chk("rstrobe", m_strobe, 1);
    chk("raddr", m_addr, a);
    chk("rtid", m_tid, t);
    tick();
  endtask

  task automatic resp(input logic [1:0] t, input logic [63:0] d, input logic e,
                      input logic [1:0] eid, input logic [63:0] ed,
                      input logic [1:0] er, input logic el);
    m_tid_out = t; m_data = d; m_err = e; m_valid = 1'b1;
    #1;
    chk("stray_on_match", m_stray, 0);
    tick();
    m_valid = 1'b0;
    chk("r_valid", r_valid, 1);
    chk("r_id", r_id, eid);
    chk("r_data", r_data, ed);
    chk("r_resp", r_resp, er);
    chk("r_last", r_last, el);
  endtask

  initial begin
    n_rst = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = 2'b01;
    ar_valid = 1'b0; r_ready = 1'b1; m_full = 1'b0; m_valid = 1'b0; m_data = '0;
    m_tid_out = '0; m_err = 1'b0;
    tick();
    tick();
    chk("rst_arready", ar_ready, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_rid", r_id, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_rresp", r_resp, 0);
    chk("rst_rlast", r_last, 0);
    chk("rst_rstrobe", m_strobe, 0);
    chk("rst_raddr", m_addr, 0);
    chk("rst_rtid", m_tid, 0);
    chk("rst_ren", m_ren, 1);
    chk("rst_stray", m_stray, 0);
    n_rst = 1'b1;
    #1;
    chk("arready_after_rst", ar_ready, 1);
    tick();

    // Full-width beats.
    do_ar(2'd0, 32'h0, 8'd1, 3'd3, 2'b01);
    iss(8'h00, 2'd0);
    iss(8'h08, 2'd0);
    #1;
    chk("rstrobe_done", m_strobe, 0);
    resp(2'd0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 2'd0, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00, 1'b0);
    resp(2'd0, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 2'd0, 64'hBBBB_BBBB_BBBB_BBBB, 2'b00, 1'b1);
    tick();
    chk("r_valid_drop", r_valid, 0);

    // Narrow beats: masking and lane shift.
    do_ar(2'd1, 32'h0, 8'd1, 3'd2, 2'b01);
    iss(8'h00, 2'd1);
    iss(8'h04, 2'd1);
    resp(2'd1, 64'hFFFF_FFFF_5A5A_5A5A, 1'b0, 2'd1, 64'h0000_0000_5A5A_5A5A, 2'b00, 1'b0);
    resp(2'd1, 64'h1234_5678_CCCC_CCCC, 1'b0, 2'd1, 64'hCCCC_CCCC_0000_0000, 2'b00, 1'b1);
    tick();
    do_ar(2'd2, 32'h0, 8'd1, 3'd0, 2'b01);
    iss(8'h00, 2'd2);
    iss(8'h01, 2'd2);
    resp(2'd2, 64'h1111_1111_1111_1172, 1'b0, 2'd2, 64'h72, 2'b00, 1'b0);
    resp(2'd2, 64'hABCD_EF01_2345_6734, 1'b0, 2'd2, 64'h3400, 2'b00, 1'b1);
    tick();
    chk("r_valid_drop2", r_valid, 0);

    // Error bursts: out of range, then non-INCR.
    do_ar(2'd3, 32'h100, 8'd0, 3'd3, 2'b01);
    #1;
    chk("err_no_strobe", m_strobe, 0);
    tick();
    chk("err_rvalid", r_valid, 1);
    chk("err_rid", r_id, 3);
    chk("err_rdata", r_data, 0);
    chk("err_rresp", r_resp, 2'b10);
    chk("err_rlast", r_last, 1);
    tick();
    chk("err_done", r_valid, 0);
    do_ar(2'd3, 32'h0, 8'd0, 3'd3, 2'b10);
    #1;
    chk("wrap_no_strobe", m_strobe, 0);
    tick();
    chk("wrap_rresp", r_resp, 2'b10);
    chk("wrap_rlast", r_last, 1);
    chk("wrap_rdata", r_data, 0);
    tick();
    chk("wrap_done", r_valid, 0);

    // Four outstanding bursts held back by rfull, then round-robin issue.
    m_full = 1'b1;
    do_ar(2'd1, 32'h00, 8'd1, 3'd3, 2'b01);
    do_ar(2'd2, 32'h10, 8'd2, 3'd3, 2'b01);
    do_ar(2'd3, 32'h40, 8'd3, 3'd3, 2'b01);
    do_ar(2'd0, 32'h80, 8'd2, 3'd3, 2'b01);
    ar_id = 2'd1;
    #1;
    chk("fifth_ar_blocked", ar_ready, 0);
    chk("rfull_no_strobe", m_strobe, 0);
    m_full = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 6) begin
        m_full = 1'b1;
        #1;
        chk("rfull_stall", m_strobe, 0);
        tick();
        m_full = 1'b0;
      end
      iss(iss_addr[k], iss_tid[k]);
    end
    #1;
    chk("all_issued", m_strobe, 0);
    for (int k = 0; k < 12; k++) begin
      resp(rsp_tid[k], 64'hDEAD_BEEF_0000_0000 | 64'(k), 1'b0,
           rsp_tid[k], 64'hDEAD_BEEF_0000_0000 | 64'(k), 2'b00, rsp_last[k]);
      if (k == 4) begin
        ar_id = 2'd1;
        #1;
        chk("dup_id_blocked", ar_ready, 0);
        ar_id = 2'd3;
        #1;
        chk("freed_id_ready", ar_ready, 1);
      end
    end
    ar_id = 2'd0;
    #1;
    chk("rlast_same_cycle_blocked", ar_ready, 0);
    tick();
    chk("rlast_next_cycle_ready", ar_ready, 1);
    chk("final_drop", r_valid, 0);

    // Backpressure, then a stray response.
    do_ar(2'd1, 32'h0, 8'd0, 3'd3, 2'b01);
    iss(8'h00, 2'd1);
    r_ready = 1'b0;
    resp(2'd1, 64'h0123_4567_89AB_CDEF, 1'b1, 2'd1, 64'h0123_4567_89AB_CDEF, 2'b10, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("hold_rvalid", r_valid, 1);
      chk("hold_rdata", r_data, 64'h0123_4567_89AB_CDEF);
      chk("hold_rid", r_id, 1);
      chk("hold_rlast", r_last, 1);
      chk("hold_ren", m_ren, 0);
      tick();
    end
    r_ready = 1'b1;
    #1;
    chk("ren_release", m_ren, 1);
    tick();
    chk("hold_done", r_valid, 0);
    m_tid_out = 2'd2; m_data = 64'h77; m_err = 1'b0; m_valid = 1'b1;
    #1;
    chk("stray_pulse", m_stray, 1);
    tick();
    m_valid = 1'b0;
    chk("stray_no_beat", r_valid, 0);
    #1;
    chk("stray_one_cycle", m_stray, 0);

    // Reset in the middle of a burst.
    do_ar(2'd2, 32'h0, 8'd3, 3'd3, 2'b01);
    iss(8'h00, 2'd2);
    resp(2'd2, 64'h55, 1'b0, 2'd2, 64'h55, 2'b00, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_rvalid", r_valid, 0);
    chk("mid_rst_rdata", r_data, 0);
    chk("mid_rst_rid", r_id, 0);
    chk("mid_rst_rlast", r_last, 0);
    chk("mid_rst_arready", ar_ready, 0);
    chk("mid_rst_rstrobe", m_strobe, 0);
    chk("mid_rst_raddr", m_addr, 0);
    chk("mid_rst_ren", m_ren, 1);
    tick();
    tick();
    n_rst = 1'b1;
    #1;
    chk("post_rst_idle", m_strobe, 0);
    chk("post_rst_no_beat", r_valid, 0);
    do_ar(2'd2, 32'h8, 8'd0, 3'd3, 2'b01);
    iss(8'h08, 2'd2);
    #1;
    chk("post_rst_issue_done", m_strobe, 0);
    resp(2'd2, 64'hCAFE, 1'b0, 2'd2, 64'hCAFE, 2'b00, 1'b1);
    tick();
    chk("post_rst_done", r_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_read_tracker.md
# axi_read_tracker

Parametrised read-path engine for the AXI subordinate. It accepts up to MAX_OUT outstanding INCR read bursts with distinct IDs and issues one beat address per cycle to the memory controller. It also takes memory responses back in any ID order, interleaved, and returns lane-shifted R beats with correct RRESP and RLAST. It sits between the AXI AR/R channels and the memory-controller read port.

## Interface
- ID_W, 2, AXI ID width
- ADDR_W, 32, AXI address width
- DATA_W, 64, data width; power of two, at least 8
- MEM_ADDR_W, 8, memory-controller address width
- MEM_BYTES, 256, decoded memory size; bytes at and above it are out of range
- MAX_OUT, 4, outstanding-burst slots
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/8/3/2  AR payload
- ARVALID  in  1 ; ARREADY  out  1  AR handshake
- RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  R payload
- RVALID  out  1 ; RREADY  in  1  R handshake
- raddr  out  MEM_ADDR_W  beat byte address
- rtid  out  ID_W  ID of issued beat
- rstrobe  out  1  beat-issue pulse
- rfull  in  1  memory request queue full
- rvalid  in  1 ; rdata  in  DATA_W ; tid_out  in  ID_W ; rerr  in  1  memory response
- ren  out  1  response accepted when rvalid && ren
- stray  out  1  one-cycle pulse: response tid_out matched no active slot

## Operation
- Each slot holds: valid, id, base addr, len, size, issue count, return count, err flag.
- ARREADY = a free slot exists AND no valid slot holds ARID. It is combinational from registered state plus ARID. A slot freed in the same cycle does not count.
- On AR handshake, the lowest free slot is filled.
- err is set if ARBURST != 2'b01, OR 1<<ARSIZE > DATA_W/8, OR ARADDR + ((ARLEN+1)<<ARSIZE) > MEM_BYTES.
- Beat n address: n=0 uses ARADDR; n>0 uses (ARADDR aligned down to 1<<size) + n<<size.
- Issue: round-robin across valid, non-err slots with issue count <= len. When !rfull, rstrobe=1 with raddr = beat address[MEM_ADDR_W-1:0] and rtid = id. The issue count increments that cycle. Err slots never issue.
- Response path: a single R output register. ren = !RVALID || RREADY.
- On rvalid && ren, look up the slot by tid_out. Load the register with:
  - RID = id
  - RDATA = (rdata masked to 1<<size bytes) << 8*(beat addr mod DATA_W/8)
  - RRESP = rerr ? 2'b10 : 2'b00
  - RLAST = (return count == len)
  Then increment the return count.
- No matching slot: the response is consumed, nothing is loaded, and stray pulses.
- Err slots: when no memory response is being accepted and the register is free, one SLVERR beat is injected (RDATA=0, RRESP=2'b10). The lowest-index err slot goes first. The beat count and RLAST follow len as normal.
- A slot frees on the handshake of its RLAST beat.
- While RVALID && !RREADY, all R outputs hold stable.

## Timing
- Reset values: all slots invalid. ARREADY=0 while n_rst low; RVALID=0, RID=0, RDATA=0, RRESP=0, RLAST=0, rstrobe=0, raddr=0, rtid=0, ren=1, stray=0.
- Reset mid-burst discards all outstanding state immediately, with no R beats emitted.
- AR accepted at edge N: the slot is valid after N, and the earliest rstrobe is in cycle N+1.
- Beat issue rate: at most 1 per cycle total. rfull=1 stalls issue with no count change.
- Memory response accepted at edge N: RVALID=1 after N. Back-to-back responses with RREADY=1 give one beat per cycle.
- Memory response and err injection in the same cycle: the memory response wins, and injection waits.
- RLAST handshake and an AR reusing that ID in the same cycle: ARREADY=0 that cycle and 1 the next.

## Test plan
- AR addr 0, len 1, size 3, id 0 -> raddr 0x00, 0x08. Responses A5A5…A5 then BBBB…BB -> RDATA equal, RRESP 0, RLAST 0 then 1.
- AR addr 0, len 1, size 2 -> raddr 0x0, 0x4. Responses 5A5A5A5A and CCCCCCCC -> RDATA 0x5A5A5A5A, then 0xCCCCCCCC00000000. Size 0: 0x72, 0x34 -> 0x72, 0x3400.
- AR addr 0x100, len 0 -> no rstrobe; one beat RRESP 2, RLAST 1, RDATA 0. ARBURST 2'b10 -> same SLVERR behaviour.
- Four ARs (ids 1,2,3,0; len 1,2,3,2) accepted back to back -> fifth AR blocked (ARREADY=0). Responses returned for id 3 first, then interleaved 1/2/0 -> each ID's RLAST appears on its own last beat; slots free; duplicate-ID AR is stalled while that ID is active.
- RREADY held low 5 cycles with RVALID=1 -> R outputs stable and ren=0. Response with tid_out of an inactive ID -> stray pulses once and no R beat is produced. rfull=1 -> no rstrobe.
- Assert n_rst mid-burst -> all outputs take their reset values asynchronously. A new AR after reset completes normally.
